fcn_in_packer: RTL

FCN_IN_PACKER -- requirements
Module: fcn_in_packer

---
 rtl/npu_pkg.sv | 32 +++
 rtl/fcn_requant.sv | 46 ++++
 rtl/fcn_in_packer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/npu_pkg.sv
// npu_pkg: constants and types shared by the FC input packer and its
// requantiser. Holds the default frame geometry, the int8 output limits and
// the packer state encoding.
package npu_pkg;

  // Default number of int8 elements the FC stage consumes per frame
  localparam int IN1_N = 132;

  // Default width of the signed feature accumulators feeding the packer
  localparam int ACC_W = 24;

  // Default requantisation right-shift
  localparam int SHIFT_DEF = 8;

  // int8 saturation limits
  localparam int Q_MAX = 127;
  localparam int Q_MIN = -128;

  // Packer sequence: collect a frame, hand it over, kick the FC stage, wait
  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_LOAD  = 2'd1,
    S_START = 2'd2,
    S_WAIT  = 2'd3
  } pack_state_e;

  // Index width for an n-entry vector; never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fcn_requant.sv
// fcn_requant: combinational accumulator-to-int8 requantiser.
// Round-half-up by adding 2^(SHIFT-1), arithmetic shift right by SHIFT,
// then saturate to the int8 range.
// Build option: define FCN_PACK_RELU_EN to clamp negative inputs to zero
// before rounding, which restricts the output to [0,127].
module fcn_requant #(
  parameter int ACC_W = npu_pkg::ACC_W,
  parameter int SHIFT = npu_pkg::SHIFT_DEF
) (
  input  logic [ACC_W-1:0] acc,
  output logic [7:0]       q
);
  import npu_pkg::*;

  // One guard bit keeps the rounding add from overflowing for any input
  localparam logic signed [ACC_W:0] RND   = $signed((ACC_W+1)'(1) << (SHIFT-1));
  localparam logic signed [ACC_W:0] MAX_Q = (ACC_W+1)'(Q_MAX);
  localparam logic signed [ACC_W:0] MIN_Q = (ACC_W+1)'(Q_MIN);

  logic signed [ACC_W:0] acc_ext;
  logic signed [ACC_W:0] acc_act;
  logic signed [ACC_W:0] rounded;
  logic signed [ACC_W:0] shifted;

  assign acc_ext = $signed({acc[ACC_W-1], acc});

  // Optional ReLU, rounding, arithmetic shift and int8 saturation
  always_comb begin
    acc_act = acc_ext;
`ifdef FCN_PACK_RELU_EN
    if (acc_ext[ACC_W]) begin
      acc_act = '0;
    end
`endif
    rounded = acc_act + RND;
    shifted = rounded >>> SHIFT;
    if (shifted > MAX_Q) begin
      q = 8'h7F;
    end else if (shifted < MIN_Q) begin
      q = 8'h80;
    end else begin
      q = shifted[7:0];
    end
  end

endmodule

// File: rtl/fcn_in_packer.sv
// fcn_in_packer: collects a stream of signed feature accumulators into an
// IN1_N-entry int8 vector for the FC stage, then strobes the vector write,
// pulses start and waits for fcn_done before taking the next frame.
// Frames ending early are zero-padded; frames running long are cut at IN1_N.
// Either length mismatch raises a one-cycle frame_err alongside the write.
// Build option: FCN_PACK_RELU_EN (ReLU before requantisation, see fcn_requant).
module fcn_in_packer #(
  parameter int IN1_N = npu_pkg::IN1_N,
  parameter int ACC_W = npu_pkg::ACC_W,
  parameter int SHIFT = npu_pkg::SHIFT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [ACC_W-1:0] s_data,
  input  logic             s_last,
  output logic             in_vec_wr,
  output logic [7:0]       in_vec_array [0:IN1_N-1],
  output logic             start,
  input  logic             fcn_done,
  output logic             busy,
  output logic             frame_err
);
  import npu_pkg::*;

  localparam int             IDX_W    = idx_width(IN1_N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN1_N - 1);

  pack_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;
  logic             live_q;

  logic [7:0] q_elem;
  logic       accept;
  logic       at_last_idx;
  logic       fill_end;
  logic       short_end;

  fcn_requant #(
    .ACC_W(ACC_W),
    .SHIFT(SHIFT)
  ) u_requant (
    .acc(s_data),
    .q  (q_elem)
  );

  // live_q keeps s_ready low while reset is held; it opens on the first edge
  assign s_ready     = live_q && (state_q == S_FILL);
  assign accept      = s_valid && s_ready;
  assign at_last_idx = (idx_q == LAST_IDX);
  assign fill_end    = accept && (s_last || at_last_idx);
  assign short_end   = accept && s_last && !at_last_idx;

  // Handshake outputs decode straight from the state register
  assign in_vec_wr = (state_q == S_LOAD);
  assign start     = (state_q == S_START);
  assign busy      = (state_q != S_FILL);
  assign frame_err = err_q;

  // Sequencer: fill index, frame-length check and state transitions
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    case (state_q)
      S_FILL: begin
        if (fill_end) begin
          state_d = S_LOAD;
          idx_d   = '0;
          // s_last on the final slot is the only well-formed ending
          err_d   = (s_last != at_last_idx);
        end else if (accept) begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_LOAD:  state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        // fcn_done only matters here; elsewhere it is ignored by construction
        if (fcn_done) begin
          state_d = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FILL;
      idx_q   <= '0;
      err_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      live_q  <= 1'b1;
    end
  end

  // One register per vector slot; writes happen only on an accept in S_FILL,
  // so the vector is frozen from S_LOAD until the next frame starts
  for (genvar gi = 0; gi < IN1_N; gi++) begin : g_vec
    localparam logic [IDX_W-1:0] SLOT = IDX_W'(gi);

    logic [7:0] elem_q, elem_d;

    // Take the requantised element at the current index; on an early
    // s_last, clear every slot beyond it in the same edge
    always_comb begin
      elem_d = elem_q;
      if (accept && (idx_q == SLOT)) begin
        elem_d = q_elem;
      end else if (short_end && (SLOT > idx_q)) begin
        elem_d = 8'h00;
      end
    end

    // Slot storage
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        elem_q <= 8'h00;
      end else begin
        elem_q <= elem_d;
      end
    end

    assign in_vec_array[gi] = elem_q;
  end

endmodule
